// File: rtl/id_ctrl_pkg.sv
// Shared decode constants and the packed ID/EX control bundle for id_stage_ctrl.
// The illegal-instruction field exists only when ILLEGAL_TRAP_EN is defined.
package id_ctrl_pkg;

  localparam int ALUC_BITS = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_MOVZ = 6'h0a;
  localparam logic [5:0] FN_MOVN = 6'h0b;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  localparam logic [ALUC_BITS-1:0] ALUC_ADDU = 4'b0000;
  localparam logic [ALUC_BITS-1:0] ALUC_SUB  = 4'b0001;
  localparam logic [ALUC_BITS-1:0] ALUC_ADD  = 4'b0010;
  localparam logic [ALUC_BITS-1:0] ALUC_AND  = 4'b0011;
  localparam logic [ALUC_BITS-1:0] ALUC_OR   = 4'b0100;
  localparam logic [ALUC_BITS-1:0] ALUC_NOR  = 4'b0101;
  localparam logic [ALUC_BITS-1:0] ALUC_XOR  = 4'b0110;
  localparam logic [ALUC_BITS-1:0] ALUC_SLL  = 4'b1000;
  localparam logic [ALUC_BITS-1:0] ALUC_SRL  = 4'b1001;
  localparam logic [ALUC_BITS-1:0] ALUC_SLLV = 4'b1010;
  localparam logic [ALUC_BITS-1:0] ALUC_SRLV = 4'b1011;
  localparam logic [ALUC_BITS-1:0] ALUC_MOVN = 4'b1100;
  localparam logic [ALUC_BITS-1:0] ALUC_MOVZ = 4'b1110;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_LUI = 2'b01,
    WB_MEM = 2'b10,
    WB_SLT = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_SIGN,
    IMM_ZERO,
    IMM_UPPER
  } imm_kind_e;

  typedef struct packed {
    logic                 rf_w;
    logic [4:0]           wdst;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [ALUC_BITS-1:0] aluc;
    logic [4:0]           shamt;
    logic                 alu_src_imm;
    wb_sel_e              wb_sel;
    logic                 dm_r;
    logic                 dm_w;
    logic                 is_beq;
    logic                 is_jump;
    logic [31:0]          imm;
    logic [31:0]          jtarget;
`ifdef ILLEGAL_TRAP_EN
    logic                 illegal;
`endif
  } ctrl_bundle_t;

  function automatic logic [31:0] ext_imm(input imm_kind_e kind, input logic [15:0] raw);
    logic [31:0] r;
    case (kind)
      IMM_SIGN:  r = {{16{raw[15]}}, raw};
      IMM_ZERO:  r = {16'h0000, raw};
      IMM_UPPER: r = {raw, 16'h0000};
      default:   r = 32'h0000_0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_stage_ctrl_if.sv
// Handshake and decoded-bundle signals between IF/ID, id_stage_ctrl and EX.
// illegal_inst is present only when ILLEGAL_TRAP_EN is defined.
interface id_stage_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int CNT_W  = 16,
  parameter int ALUC_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   inst;
  logic [XLEN-1:0]   pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              rf_w;
  logic [4:0]        wdst;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [ALUC_W-1:0] aluc;
  logic [4:0]        shamt;
  logic              alu_src_imm;
  logic [1:0]        wb_sel;
  logic              dm_r;
  logic              dm_w;
  logic              is_beq;
  logic              is_jump;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   jtarget;
  logic [XLEN-1:0]   pc_out;
  logic [CNT_W-1:0]  stall_cnt;
`ifdef ILLEGAL_TRAP_EN
  logic              illegal_inst;
`endif

  // Pipeline-side view: feeds instructions, flush and EX backpressure.
  modport master (
    output in_valid, inst, pc, flush, out_ready,
    input  in_ready, out_valid, rf_w, wdst, rs, rt, aluc, shamt, alu_src_imm,
           wb_sel, dm_r, dm_w, is_beq, is_jump, imm, jtarget, pc_out, stall_cnt
`ifdef ILLEGAL_TRAP_EN
    , input illegal_inst
`endif
  );

  modport slave (
    input  in_valid, inst, pc, flush, out_ready,
    output in_ready, out_valid, rf_w, wdst, rs, rt, aluc, shamt, alu_src_imm,
           wb_sel, dm_r, dm_w, is_beq, is_jump, imm, jtarget, pc_out, stall_cnt
`ifdef ILLEGAL_TRAP_EN
    , output illegal_inst
`endif
  );

endinterface

// File: rtl/id_decode_comb.sv
// Pure combinational MIPS decoder: instruction word -> control bundle plus
// source-usage flags for the interlock. ILLEGAL_TRAP_EN marks unknown encodings.
module id_decode_comb
  import id_ctrl_pkg::*;
(
  input  logic [31:0]  inst,
  input  logic [29:0]  pc_word,
  output ctrl_bundle_t bundle,
  output logic         uses_rs,
  output logic         uses_rt
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [3:0] pc_hi;
  logic       known;
  imm_kind_e  kind;

  assign opcode = inst[31:26];
  assign funct  = inst[5:0];
  // Upper nibble of pc+4 without building the full adder: carry only when pc[27:2] is all ones.
  assign pc_hi  = pc_word[29:26] + {3'b000, &pc_word[25:0]};

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a value unassigned (no latch).
    bundle         = '0;
    uses_rs        = 1'b0;
    uses_rt        = 1'b0;
    known          = 1'b1;
    kind           = IMM_NONE;
    bundle.rs      = inst[25:21];
    bundle.rt      = inst[20:16];
    bundle.shamt   = inst[10:6];
    bundle.jtarget = {pc_hi, inst[25:0], 2'b00};

    case (opcode)
      OP_RTYPE: begin
        bundle.rf_w = 1'b1;
        bundle.wdst = inst[15:11];
        uses_rs     = 1'b1;
        uses_rt     = 1'b1;
        case (funct)
          FN_ADD:  bundle.aluc = ALUC_ADD;
          FN_SUB:  bundle.aluc = ALUC_SUB;
          FN_AND:  bundle.aluc = ALUC_AND;
          FN_OR:   bundle.aluc = ALUC_OR;
          FN_XOR:  bundle.aluc = ALUC_XOR;
          FN_NOR:  bundle.aluc = ALUC_NOR;
          FN_SLLV: bundle.aluc = ALUC_SLLV;
          FN_SRLV: bundle.aluc = ALUC_SRLV;
          FN_MOVN: bundle.aluc = ALUC_MOVN;
          FN_MOVZ: bundle.aluc = ALUC_MOVZ;
          FN_SLL: begin
            bundle.aluc = ALUC_SLL;
            uses_rs     = 1'b0;
          end
          FN_SRL: begin
            bundle.aluc = ALUC_SRL;
            uses_rs     = 1'b0;
          end
          default: known = 1'b0;
        endcase
      end
      OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
        bundle.rf_w        = 1'b1;
        bundle.wdst        = inst[20:16];
        bundle.alu_src_imm = 1'b1;
        uses_rs            = (opcode != OP_LUI);
        case (opcode)
          OP_SLTI: begin
            bundle.aluc   = ALUC_SUB;
            bundle.wb_sel = WB_SLT;
            kind          = IMM_SIGN;
          end
          OP_ANDI: begin
            bundle.aluc = ALUC_AND;
            kind        = IMM_ZERO;
          end
          OP_ORI: begin
            bundle.aluc = ALUC_OR;
            kind        = IMM_ZERO;
          end
          OP_XORI: begin
            bundle.aluc = ALUC_XOR;
            kind        = IMM_ZERO;
          end
          OP_LUI: begin
            bundle.wb_sel = WB_LUI;
            kind          = IMM_UPPER;
          end
          OP_LW: begin
            bundle.dm_r   = 1'b1;
            bundle.wb_sel = WB_MEM;
            kind          = IMM_SIGN;
          end
          default: kind = IMM_SIGN;
        endcase
      end
      OP_SW: begin
        bundle.dm_w        = 1'b1;
        bundle.wdst        = inst[20:16];
        bundle.alu_src_imm = 1'b1;
        kind               = IMM_SIGN;
        uses_rs            = 1'b1;
        uses_rt            = 1'b1;
      end
      OP_BEQ: begin
        bundle.is_beq = 1'b1;
        bundle.wdst   = inst[20:16];
        bundle.aluc   = ALUC_SUB;
        kind          = IMM_SIGN;
        uses_rs       = 1'b1;
        uses_rt       = 1'b1;
      end
      OP_J:    bundle.is_jump = 1'b1;
      default: known = 1'b0;
    endcase

    // nop and unknown encodings leave only the raw instruction fields behind.
    if (inst == 32'h0000_0000 || !known) begin
      bundle.rf_w        = 1'b0;
      bundle.wdst        = 5'd0;
      bundle.aluc        = ALUC_ADDU;
      bundle.alu_src_imm = 1'b0;
      bundle.wb_sel      = WB_ALU;
      bundle.dm_r        = 1'b0;
      bundle.dm_w        = 1'b0;
      bundle.is_beq      = 1'b0;
      bundle.is_jump     = 1'b0;
      kind               = IMM_NONE;
      uses_rs            = 1'b0;
      uses_rt            = 1'b0;
    end

`ifdef ILLEGAL_TRAP_EN
    bundle.illegal = !known;
`endif
    bundle.imm = ext_imm(kind, inst[15:0]);
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Registered ID stage: decode, valid/ready handshake, load-use interlock, flush
// and saturating stall counter. Define ILLEGAL_TRAP_EN to add illegal_inst.
module id_stage_ctrl
  import id_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CNT_W  = 16,
  parameter int ALUC_W = 4
) (
  input logic           clk,
  input logic           rst,
  id_stage_ctrl_if.slave bus
);

  if (XLEN != 32) begin : g_xlen_check
    $error("id_stage_ctrl: XLEN must be 32");
  end
  if (ALUC_W != ALUC_BITS) begin : g_aluc_check
    $error("id_stage_ctrl: ALUC_W must match the package ALU code width");
  end

  ctrl_bundle_t     dec;
  ctrl_bundle_t     bundle_q;
  logic             uses_rs;
  logic             uses_rt;
  logic             out_valid_q;
  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] stall_q;
  logic             hazard;
  logic             in_ready;
  logic             accept;
  logic             valid_d;
  logic             bump;

  id_decode_comb u_decode (
    .inst    (bus.inst),
    .pc_word (bus.pc[XLEN-1:2]),
    .bundle  (dec),
    .uses_rs (uses_rs),
    .uses_rt (uses_rt)
  );

  // A held load whose destination feeds the incoming instruction must drain first.
  assign hazard = bus.in_valid & out_valid_q & bundle_q.dm_r & (bundle_q.wdst != 5'd0) &
                  ((uses_rs & (bundle_q.wdst == dec.rs)) | (uses_rt & (bundle_q.wdst == dec.rt)));

  assign in_ready = (~out_valid_q | bus.out_ready) & ~hazard & ~bus.flush;
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    valid_d = out_valid_q;
    bump    = 1'b0;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (bus.out_ready) begin
      // EX took the bundle and nothing replaces it; under a hazard this empty slot is the bubble.
      valid_d = 1'b0;
      bump    = hazard & (stall_q != {CNT_W{1'b1}});
    end
  end

  // NOTE: the whole ID/EX register is a handful of flops, so every bit is reset, not just out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      pc_q        <= '0;
      stall_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update sampled from pre-edge values.
      out_valid_q <= valid_d;
      if (accept) begin
        bundle_q <= dec;
        pc_q     <= bus.pc;
      end
      if (bump) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.rf_w        = bundle_q.rf_w;
  assign bus.wdst        = bundle_q.wdst;
  assign bus.rs          = bundle_q.rs;
  assign bus.rt          = bundle_q.rt;
  assign bus.aluc        = bundle_q.aluc;
  assign bus.shamt       = bundle_q.shamt;
  assign bus.alu_src_imm = bundle_q.alu_src_imm;
  assign bus.wb_sel      = bundle_q.wb_sel;
  assign bus.dm_r        = bundle_q.dm_r;
  assign bus.dm_w        = bundle_q.dm_w;
  assign bus.is_beq      = bundle_q.is_beq;
  assign bus.is_jump     = bundle_q.is_jump;
  assign bus.imm         = bundle_q.imm;
  assign bus.jtarget     = bundle_q.jtarget;
  assign bus.pc_out      = pc_q;
  assign bus.stall_cnt   = stall_q;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal_inst = bundle_q.illegal;
`endif

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Self-checking bench for id_stage_ctrl: decode vector table through a scoreboard,
// plus hand sequences for interlock, flush, backpressure and asynchronous reset.
module tb_id_stage_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_stage_ctrl_if bus ();

  id_stage_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        rf_w;
    logic [4:0]  wdst;
    logic [3:0]  aluc;
    logic        src;
    logic [1:0]  wb;
    logic        dm_r;
    logic        dm_w;
    logic        beq;
    logic        jmp;
    logic [31:0] imm;
    logic [31:0] jt;
    logic        ill;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(logic [31:0] inst, logic [31:0] pc, logic rf_w, logic [4:0] wdst,
                              logic [3:0] aluc, logic src, logic [1:0] wb, logic dm_r, logic dm_w,
                              logic beq, logic jmp, logic [31:0] imm, logic [31:0] jt, logic ill);
    vec_t v;
    v.inst = inst; v.pc = pc; v.rf_w = rf_w; v.wdst = wdst; v.aluc = aluc; v.src = src;
    v.wb = wb; v.dm_r = dm_r; v.dm_w = dm_w; v.beq = beq; v.jmp = jmp; v.imm = imm;
    v.jt = jt; v.ill = ill;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic compare_bundle(input vec_t e);
    string t;
    t = $sformatf("i%08h", e.inst);
    check({t, ".rf_w"},   32'(bus.rf_w),        32'(e.rf_w));
    check({t, ".wdst"},   32'(bus.wdst),        32'(e.wdst));
    check({t, ".aluc"},   32'(bus.aluc),        32'(e.aluc));
    check({t, ".src"},    32'(bus.alu_src_imm), 32'(e.src));
    check({t, ".wb_sel"}, 32'(bus.wb_sel),      32'(e.wb));
    check({t, ".dm_r"},   32'(bus.dm_r),        32'(e.dm_r));
    check({t, ".dm_w"},   32'(bus.dm_w),        32'(e.dm_w));
    check({t, ".beq"},    32'(bus.is_beq),      32'(e.beq));
    check({t, ".jump"},   32'(bus.is_jump),     32'(e.jmp));
    check({t, ".imm"},    bus.imm,              e.imm);
    check({t, ".pc_out"}, bus.pc_out,           e.pc);
    check({t, ".rs"},     32'(bus.rs),          32'(e.inst[25:21]));
    check({t, ".rt"},     32'(bus.rt),          32'(e.inst[20:16]));
    check({t, ".shamt"},  32'(bus.shamt),       32'(e.inst[10:6]));
    if (e.jmp) check({t, ".jtarget"}, bus.jtarget, e.jt);
`ifdef ILLEGAL_TRAP_EN
    check({t, ".illegal"}, 32'(bus.illegal_inst), 32'(e.ill));
`endif
  endtask

  // One clock: called just after a falling edge with inputs set; samples 1 ns later.
  task automatic cycle(input vec_t e, output logic acc);
    #1;
    acc = bus.in_valid & bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: out_valid=1 with no pending bundle, wdst=%0d", bus.wdst);
      end else begin
        compare_bundle(sb_q.pop_front());
      end
    end else if (bus.flush && bus.out_valid && sb_q.size() > 0) begin
      void'(sb_q.pop_front());
    end
    if (acc) sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic issue(input vec_t e, output int waits);
    logic acc;
    acc   = 1'b0;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.inst     = e.inst;
    bus.pc       = e.pc;
    for (int n = 0; n < 20; n++) begin
      cycle(e, acc);
      if (acc) break;
      waits++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: inst %h not accepted in 20 cycles", e.inst);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    vec_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(z, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v_add, v_lw2, v_addiu, v_lui, v_sw2, v_lw0, v_addiu0, v_j, v_or, v_xor;
    int   w;
    logic acc;

    v_add    = mk(32'h0022_1820, 32'h0000_1000, 1, 3, 4'h2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    v_lw2    = mk(32'h8C22_0000, 32'h0000_2000, 1, 2, 4'h0, 1, 2'b10, 1, 0, 0, 0, 0, 0, 0);
    v_addiu  = mk(32'h2443_0001, 32'h0000_2004, 1, 3, 4'h0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0);
    v_lui    = mk(32'h3C02_0005, 32'h0000_2008, 1, 2, 4'h0, 1, 2'b01, 0, 0, 0, 0, 32'h0005_0000, 0, 0);
    v_sw2    = mk(32'hAC82_0000, 32'h0000_200C, 0, 2, 4'h0, 1, 2'b00, 0, 1, 0, 0, 0, 0, 0);
    v_lw0    = mk(32'h8C20_0000, 32'h0000_2010, 1, 0, 4'h0, 1, 2'b10, 1, 0, 0, 0, 0, 0, 0);
    v_addiu0 = mk(32'h2403_0001, 32'h0000_2014, 1, 3, 4'h0, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0);
    v_j      = mk(32'h0800_0040, 32'h1000_0000, 0, 0, 4'h0, 0, 2'b00, 0, 0, 0, 1, 0, 32'h1000_0100, 0);
    v_or     = mk(32'h016C_5025, 32'h0000_3000, 1, 10, 4'h4, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    v_xor    = mk(32'h01CF_6826, 32'h0000_3004, 1, 13, 4'h6, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    //              inst          pc            rf wd aluc src wb  dr dw bq jp imm           jtarget       ill
    tbl.push_back(mk(32'h0022_1820, 0,            1, 3, 4'h2, 0, 2'd0, 0, 0, 0, 0, 32'h0,        0,            0));
    tbl.push_back(mk(32'h00A6_2022, 0,            1, 4, 4'h1, 0, 2'd0, 0, 0, 0, 0, 32'h0,        0,            0));
    tbl.push_back(mk(32'h0109_3824, 0,            1, 7, 4'h3, 0, 2'd0, 0, 0, 0, 0, 32'h0,        0,            0));
    tbl.push_back(mk(32'h016C_5025, 0,            1, 10, 4'h4, 0, 2'd0, 0, 0, 0, 0, 32'h0,       0,            0));
    tbl.push_back(mk(32'h01CF_6826, 0,            1, 13, 4'h6, 0, 2'd0, 0, 0, 0, 0, 32'h0,       0,            0));
    tbl.push_back(mk(32'h0232_8027, 0,            1, 16, 4'h5, 0, 2'd0, 0, 0, 0, 0, 32'h0,       0,            0));
    tbl.push_back(mk(32'h0002_0900, 0,            1, 1, 4'h8, 0, 2'd0, 0, 0, 0, 0, 32'h0,        0,            0));
    tbl.push_back(mk(32'h0004_1FC2, 0,            1, 3, 4'h9, 0, 2'd0, 0, 0, 0, 0, 32'h0,        0,            0));
    tbl.push_back(mk(32'h00E6_2804, 0,            1, 5, 4'hA, 0, 2'd0, 0, 0, 0, 0, 32'h0,        0,            0));
    tbl.push_back(mk(32'h0149_4006, 0,            1, 8, 4'hB, 0, 2'd0, 0, 0, 0, 0, 32'h0,        0,            0));
    tbl.push_back(mk(32'h018D_580B, 0,            1, 11, 4'hC, 0, 2'd0, 0, 0, 0, 0, 32'h0,       0,            0));
    tbl.push_back(mk(32'h01F0_700A, 0,            1, 14, 4'hE, 0, 2'd0, 0, 0, 0, 0, 32'h0,       0,            0));
    tbl.push_back(mk(32'h2443_0001, 0,            1, 3, 4'h0, 1, 2'd0, 0, 0, 0, 0, 32'h1,        0,            0));
    tbl.push_back(mk(32'h24A4_FFFF, 0,            1, 4, 4'h0, 1, 2'd0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0,           0));
    tbl.push_back(mk(32'h28E6_8000, 0,            1, 6, 4'h1, 1, 2'd3, 0, 0, 0, 0, 32'hFFFF_8000, 0,           0));
    tbl.push_back(mk(32'h3128_8001, 0,            1, 8, 4'h3, 1, 2'd0, 0, 0, 0, 0, 32'h0000_8001, 0,           0));
    tbl.push_back(mk(32'h356A_FFFF, 0,            1, 10, 4'h4, 1, 2'd0, 0, 0, 0, 0, 32'h0000_FFFF, 0,          0));
    tbl.push_back(mk(32'h39AC_1234, 0,            1, 12, 4'h6, 1, 2'd0, 0, 0, 0, 0, 32'h0000_1234, 0,          0));
    tbl.push_back(mk(32'h3C02_0005, 0,            1, 2, 4'h0, 1, 2'd1, 0, 0, 0, 0, 32'h0005_0000, 0,           0));
    tbl.push_back(mk(32'h8C22_0000, 0,            1, 2, 4'h0, 1, 2'd2, 1, 0, 0, 0, 32'h0,        0,            0));
    tbl.push_back(mk(32'hACC5_FFFC, 0,            0, 5, 4'h0, 1, 2'd0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0,           0));
    tbl.push_back(mk(32'h1022_FFFE, 0,            0, 2, 4'h1, 0, 2'd0, 0, 0, 1, 0, 32'hFFFF_FFFE, 0,           0));
    tbl.push_back(mk(32'h0800_0040, 32'h1000_0000, 0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 1, 32'h0,       32'h1000_0100, 0));
    tbl.push_back(mk(32'h0BFF_FFFF, 32'hF000_0FFC, 0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 1, 32'h0,       32'hFFFF_FFFC, 0));
    tbl.push_back(mk(32'h0800_0040, 32'h0FFF_FFFC, 0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 1, 32'h0,       32'h1000_0100, 0));
    tbl.push_back(mk(32'h0000_0000, 0,            0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 0, 32'h0,        0,            0));
    tbl.push_back(mk(32'hFC00_0000, 0,            0, 0, 4'h0, 0, 2'd0, 0, 0, 0, 0, 32'h0,        0,            1));

    bus.in_valid  = 1'b0;
    bus.inst      = '0;
    bus.pc        = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #2;
    check("rst.out_valid", 32'(bus.out_valid), 0);
    check("rst.rf_w",      32'(bus.rf_w),      0);
    check("rst.imm",       bus.imm,            0);
    check("rst.pc_out",    bus.pc_out,         0);
    check("rst.stall_cnt", 32'(bus.stall_cnt), 0);
    check("rst.in_ready",  32'(bus.in_ready),  1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // add with one-cycle latency
    issue(v_add, w);
    check("add.latency_valid", 32'(bus.out_valid), 1);
    idle(2);

    // Load-use through rs: one stall cycle, one bubble
    issue(v_lw2, w);
    issue(v_addiu, w);
    check("lu_rs.stall_cycles", 32'(w), 1);
    check("lu_rs.stall_cnt", 32'(bus.stall_cnt), 1);
    idle(2);

    // lui does not read rs: no interlock
    issue(v_lw2, w);
    issue(v_lui, w);
    check("lu_lui.stall_cycles", 32'(w), 0);
    check("lu_lui.stall_cnt", 32'(bus.stall_cnt), 1);
    idle(2);

    // Load-use through rt of a store
    issue(v_lw2, w);
    issue(v_sw2, w);
    check("lu_rt.stall_cycles", 32'(w), 1);
    check("lu_rt.stall_cnt", 32'(bus.stall_cnt), 2);
    idle(2);

    // Load to $0 never interlocks
    issue(v_lw0, w);
    issue(v_addiu0, w);
    check("lu_r0.stall_cycles", 32'(w), 0);
    check("lu_r0.stall_cnt", 32'(bus.stall_cnt), 2);
    idle(2);

    // Hazard under EX backpressure: no bubble counted until EX drains the load
    issue(v_lw2, w);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.inst      = v_addiu.inst;
    bus.pc        = v_addiu.pc;
    for (int i = 0; i < 2; i++) begin
      cycle(v_addiu, acc);
      check("lu_bp.no_accept", 32'(acc), 0);
    end
    check("lu_bp.stall_hold", 32'(bus.stall_cnt), 2);
    bus.out_ready = 1'b1;
    issue(v_addiu, w);
    check("lu_bp.stall_cycles", 32'(w), 1);
    check("lu_bp.stall_cnt", 32'(bus.stall_cnt), 3);
    idle(2);

    // Decode table, back to back
    for (int i = 0; i < tbl.size(); i++) begin
      if (!tbl[i].jmp) tbl[i].pc = 32'h0040_0000 + 32'(i * 4);
      issue(tbl[i], w);
    end
    idle(3);
    check("table.stall_cnt", 32'(bus.stall_cnt), 3);

    // Jump then flush: the instruction offered with flush is dropped
    issue(v_j, w);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.inst     = v_add.inst;
    bus.pc       = 32'h1000_0004;
    cycle(v_add, acc);
    check("flush.in_ready", 32'(acc), 0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush.out_valid", 32'(bus.out_valid), 0);
    idle(2);

    // Flush kills a held bundle EX has not taken
    issue(v_add, w);
    bus.out_ready = 1'b0;
    bus.flush     = 1'b1;
    idle(1);
    bus.flush     = 1'b0;
    check("flush_held.out_valid", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b1;
    idle(1);

    // Backpressure hold for 3 cycles, then asynchronous reset mid-hold
    issue(v_or, w);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.inst      = v_xor.inst;
    bus.pc        = v_xor.pc;
    for (int i = 0; i < 3; i++) begin
      cycle(v_xor, acc);
      check("hold.in_ready",  32'(bus.in_ready),  0);
      check("hold.out_valid", 32'(bus.out_valid), 1);
      check("hold.wdst",      32'(bus.wdst),      10);
      check("hold.aluc",      32'(bus.aluc),      4);
      check("hold.pc_out",    bus.pc_out,         v_or.pc);
    end
    #3;
    rst = 1'b1;
    #1;
    check("arst.out_valid", 32'(bus.out_valid), 0);
    check("arst.rf_w",      32'(bus.rf_w),      0);
    check("arst.wdst",      32'(bus.wdst),      0);
    check("arst.aluc",      32'(bus.aluc),      0);
    check("arst.pc_out",    bus.pc_out,         0);
    check("arst.stall_cnt", 32'(bus.stall_cnt), 0);
    sb_q.delete();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Recovery after reset
    issue(v_add, w);
    idle(3);
    check("sb.drained", 32'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
